// File: rtl/spi_sram_master.sv
// spi_sram_master
//   Single-byte SPI SRAM master, SPI mode 0, MSB first. Converts CPU-side
//   memory requests into READ (0x03) / WRITE (0x02) frames of
//   cmd + 24-bit address + data byte, then issues CS_DELAY trailing sck
//   pulses with cs_n high so the downstream slave can retire its frame.
//
//   Optional feature macro: SPI_SRAM_FAST_READ_EN
//     defined   -> reads use FAST READ 0x0B + 8 dummy bits (48-bit frame)
//     undefined -> reads use READ 0x03 (40-bit frame)
//
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only while idle)
//   req_wr/req_addr/req_wdata request fields, sampled at accept only
//   rsp_valid                one-clk pulse at end of every frame
//   rsp_rdata                read data, held until the next read completes
//   busy                     inverse of req_ready
//   spi_sck/spi_cs_n/spi_mosi/spi_miso  SPI bus (outputs all registered)
module spi_sram_master #(
  parameter int CLK_DIV  = 2,
  parameter int CS_DELAY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

`ifdef SPI_SRAM_FAST_READ_EN
  localparam logic [7:0] RD_CMD  = 8'h0B;
  localparam int         RD_BITS = 48;
`else
  localparam logic [7:0] RD_CMD  = 8'h03;
  localparam int         RD_BITS = 40;
`endif
  localparam logic [7:0] WR_CMD  = 8'h02;
  localparam int         WR_BITS = 40;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (CS_DELAY > 1) ? $clog2(CS_DELAY) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_END, S_GAP
  } state_t;

  state_t            state_reg, state_next;
  logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
  logic [5:0]        bit_cnt_reg, bit_cnt_next;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
  logic [47:0]       tx_reg, tx_next;
  logic [7:0]        rx_reg, rx_next;
  logic              wr_reg, wr_next;
  logic              sck_reg, sck_next;
  logic              cs_n_reg, cs_n_next;
  logic              mosi_reg, mosi_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [7:0]        rdata_reg, rdata_next;
  logic              tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      div_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      gap_cnt_reg   <= '0;
      tx_reg        <= '0;
      rx_reg        <= '0;
      wr_reg        <= 1'b0;
      sck_reg       <= 1'b0;
      cs_n_reg      <= 1'b1;
      mosi_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      div_cnt_reg   <= div_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      tx_reg        <= tx_next;
      rx_reg        <= rx_next;
      wr_reg        <= wr_next;
      sck_reg       <= sck_next;
      cs_n_reg      <= cs_n_next;
      mosi_reg      <= mosi_next;
      rsp_valid_reg <= rsp_valid_next;
      rdata_reg     <= rdata_next;
    end
  end

  // One tick per sck half-period; the divider only runs while a frame or
  // its trailer is in progress.
  assign tick = (state_reg != S_IDLE) && (div_cnt_reg == '0);

  always_comb begin
    state_next     = state_reg;
    div_cnt_next   = div_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    tx_next        = tx_reg;
    rx_next        = rx_reg;
    wr_next        = wr_reg;
    sck_next       = sck_reg;
    cs_n_next      = cs_n_reg;
    mosi_next      = mosi_reg;
    rsp_valid_next = 1'b0;
    rdata_next     = rdata_reg;

    if (state_reg != S_IDLE)
      div_cnt_next = tick ? DIV_LOAD : div_cnt_reg - 1'b1;

    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          state_next   = S_SETUP;
          div_cnt_next = DIV_LOAD;
          cs_n_next    = 1'b0;
          wr_next      = req_wr;
          // Reads pad with zeros: dummy byte (fast read) and data slot.
          tx_next      = req_wr ? {WR_CMD, req_addr, req_wdata, 8'h00}
                                : {RD_CMD, req_addr, 16'h0000};
          mosi_next    = tx_next[47];
          bit_cnt_next = req_wr ? 6'(WR_BITS - 1) : 6'(RD_BITS - 1);
        end
      end
      S_SETUP, S_SHIFT: begin
        if (tick) begin
          if (!sck_reg) begin
            // Rising edge: sample miso; the last bit ends the frame.
            sck_next   = 1'b1;
            rx_next    = {rx_reg[6:0], spi_miso};
            state_next = (bit_cnt_reg == '0) ? S_END : S_SHIFT;
          end else begin
            // Falling edge: present the next bit.
            sck_next     = 1'b0;
            tx_next      = {tx_reg[46:0], 1'b0};
            mosi_next    = tx_reg[46];
            bit_cnt_next = bit_cnt_reg - 1'b1;
          end
        end
      end
      S_END: begin
        if (tick) begin
          sck_next       = 1'b0;
          cs_n_next      = 1'b1;
          mosi_next      = 1'b0;
          rsp_valid_next = 1'b1;
          if (!wr_reg)
            rdata_next = rx_reg;
          gap_cnt_next = GAP_LOAD;
          state_next   = S_GAP;
        end
      end
      S_GAP: begin
        if (tick) begin
          if (!sck_reg) begin
            sck_next = 1'b1;
          end else begin
            sck_next = 1'b0;
            if (gap_cnt_reg == '0)
              state_next = S_IDLE;
            else
              gap_cnt_next = gap_cnt_reg - 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign req_ready = (state_reg == S_IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rdata_reg;
  assign spi_sck   = sck_reg;
  assign spi_cs_n  = cs_n_reg;
  assign spi_mosi  = mosi_reg;

endmodule

// File: tb/tb_spi_sram_master.sv
// tb_spi_sram_master
//   Drives spi_sram_master against a behavioural SPI SRAM slave and a
//   byte-addressed reference memory; directed cases followed by random
//   read/write traffic over a small address window.
module tb_spi_sram_master;

  localparam int CLK_DIV  = 2;
  localparam int CS_DELAY = 3;
`ifdef SPI_SRAM_FAST_READ_EN
  localparam int RD_BITS    = 48;
  localparam int DATA_START = 40;
  localparam logic [7:0] RD_CMD = 8'h0B;
`else
  localparam int RD_BITS    = 40;
  localparam int DATA_START = 32;
  localparam logic [7:0] RD_CMD = 8'h03;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [23:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        busy;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  spi_sram_master #(.CLK_DIV(CLK_DIV), .CS_DELAY(CS_DELAY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Slave-side memory and reference memory; untouched bytes follow a
  // fixed address-derived pattern.
  logic [7:0] slave_mem [int];
  logic [7:0] model_mem [int];

  function automatic logic [7:0] init_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hC3;
  endfunction

  // Behavioural slave + bus monitor.
  logic [63:0] cap = '0;
  int rise_cnt  = 0;
  int gap_rises = 0;
  int rsp_cnt   = 0;
  int bad_rsp   = 0;
  logic [7:0] rd_byte = '0;

  always @(negedge spi_cs_n) begin
    rise_cnt  = 0;
    gap_rises = 0;
    cap       = '0;
  end

  always @(posedge spi_sck) begin
    if (!spi_cs_n) begin
      cap = {cap[62:0], spi_mosi};
      rise_cnt++;
      if (rise_cnt == 32 && cap[31:24] == RD_CMD)
        rd_byte = slave_mem.exists(int'(cap[23:0])) ? slave_mem[int'(cap[23:0])]
                                                     : init_byte(cap[23:0]);
    end else begin
      gap_rises++;
    end
  end

  always @(negedge spi_sck) begin
    if (!spi_cs_n && rise_cnt >= DATA_START && rise_cnt - DATA_START < 8)
      spi_miso = rd_byte[7 - (rise_cnt - DATA_START)];
  end

  always @(posedge spi_cs_n) begin
    if (rise_cnt == 40 && cap[39:32] == 8'h02)
      slave_mem[int'(cap[31:8])] = cap[7:0];
  end

  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_cnt++;
      if (!spi_cs_n) bad_rsp++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [23:0] a, input logic [7:0] d);
    int cyc;
    int rsp0;
    int fb;
    logic [63:0] exp_bits;
    logic [63:0] mask;
    logic [7:0]  exp_rd;
    @(negedge clk);
    check("ready_before", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    rsp0      = rsp_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    req_wr    = $urandom_range(0, 1);
    req_addr  = 24'($urandom);
    req_wdata = 8'($urandom);
    cyc = 0;
    while (!req_ready && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("done_in_time", {63'd0, cyc < 2000}, 64'd1);
    if (wr) begin
      fb       = 40;
      exp_bits = {24'd0, 8'h02, a, d};
    end else begin
      fb = RD_BITS;
`ifdef SPI_SRAM_FAST_READ_EN
      exp_bits = {16'd0, RD_CMD, a, 16'h0000};
`else
      exp_bits = {24'd0, RD_CMD, a, 8'h00};
`endif
    end
    mask = (64'd1 << fb) - 64'd1;
    check("frame_rises", 64'(rise_cnt), 64'(fb));
    check("mosi_bits", cap & mask, exp_bits);
    check("gap_rises", 64'(gap_rises), 64'(CS_DELAY));
    check("rsp_pulses", 64'(rsp_cnt - rsp0), 64'd1);
    check("rsp_cs_high", 64'(bad_rsp), 64'd0);
    if (wr) begin
      model_mem[int'(a)] = d;
    end else begin
      exp_rd = model_mem.exists(int'(a)) ? model_mem[int'(a)] : init_byte(a);
      check("rdata", {56'd0, rsp_rdata}, {56'd0, exp_rd});
    end
    $display("txn %s addr=%06h wdata=%02h rdata=%02h rises=%0d gap=%0d",
             wr ? "WR" : "RD", a, d, rsp_rdata, rise_cnt, gap_rises);
  endtask

  initial begin
    int cyc;
    int rsp0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_wr = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, req_ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_sck", {63'd0, spi_sck}, 64'd0);
    check("rst_cs_n", {63'd0, spi_cs_n}, 64'd1);
    check("rst_mosi", {63'd0, spi_mosi}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rdata", {56'd0, rsp_rdata}, 64'd0);
    rst = 1'b0;

    // Directed cases.
    do_req(1'b1, 24'h012345, 8'hA5);
    slave_mem[16] = 8'h3C;
    model_mem[16] = 8'h3C;
    do_req(1'b0, 24'h000010, 8'h00);
    do_req(1'b1, 24'h00FFFF, 8'h77);
    do_req(1'b0, 24'h00FFFF, 8'h00);
    do_req(1'b0, 24'hABCDEF, 8'h00);

    // Reset in the middle of a read frame.
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 24'h00FFFF;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (rise_cnt < 20 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_bit20", {63'd0, cyc < 1000}, 64'd1);
    rsp0 = rsp_cnt;
    rst = 1'b1;
    #1;
    check("abort_cs_n", {63'd0, spi_cs_n}, 64'd1);
    check("abort_sck", {63'd0, spi_sck}, 64'd0);
    check("abort_ready", {63'd0, req_ready}, 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_rsp", 64'(rsp_cnt - rsp0), 64'd0);
    check("abort_no_trailer", 64'(gap_rises), 64'd0);
    check("abort_idle_sck", {63'd0, spi_sck}, 64'd0);
    $display("txn RST abort at rise %0d", rise_cnt);
    do_req(1'b0, 24'h00FFFF, 8'h00);

    // Random traffic over a small window so reads hit earlier writes.
    for (int i = 0; i < 16; i++) begin
      do_req(1'($urandom_range(0, 1)), 24'h000100 + 24'($urandom_range(0, 7)),
             8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
